// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM sample path: sequencer states and midscale helper.
package pdm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_RUN     = 2'd2,
        ST_RAMP    = 2'd3
    } pdm_seq_state_t;

    // Midscale (silence) code for an offset-binary sample of the given width.
    function automatic logic [31:0] pdm_mid(input int unsigned nbits);
        return 32'h1 << (nbits - 1);
    endfunction

endpackage

// File: rtl/pdm_sample_fifo.sv
// Small synchronous FIFO holding samples between the producer and the sequencer.
module pdm_sample_fifo #(
    parameter  int NBITS = 16,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [NBITS-1:0] i_wdata,
    output logic [NBITS-1:0] o_rdata,
    output logic [LW-1:0]    o_level,
    output logic             o_full,
    output logic             o_empty
);

    logic [NBITS-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [LW-1:0]    r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    // Flush wins over any push/pop in the same cycle; overflow/underflow attempts are dropped.
    assign w_do_push = i_push && !o_full  && !i_flush;
    assign w_do_pop  = i_pop  && !o_empty && !i_flush;

    // Sample storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr] <= i_wdata;
    end

    // Pointers wrap naturally (power-of-two depth); a separate count keeps full/empty unambiguous.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + LW'(w_do_push) - LW'(w_do_pop);
        end
    end

    assign o_rdata = r_mem[r_rd];
    assign o_level = r_cnt;
    assign o_full  = (r_cnt == LW'(DEPTH));
    assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/pdm_sample_sequencer.sv
// Releases buffered samples to the PDM at a programmable rate; ramps to midscale on underrun/disable.
module pdm_sample_sequencer
    import pdm_pkg::*;
#(
    parameter int               NBITS     = 16,
    parameter int               DEPTH     = 4,
    parameter int               DIV_W     = 16,
    parameter logic [NBITS-1:0] RAMP_STEP = 16'h1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DIV_W-1:0]      div,
    input  logic [NBITS-1:0]      s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [NBITS-1:0]      pdm_din,
    output logic                  sample_tick,
    output logic                  underrun,
    input  logic                  underrun_clr,
    output logic [$clog2(DEPTH):0] level
);

    localparam int               LW     = $clog2(DEPTH) + 1;
    localparam logic [NBITS-1:0] MID    = NBITS'(pdm_mid(NBITS));
    localparam logic [LW-1:0]    L_HALF = LW'(DEPTH / 2);

    pdm_seq_state_t   r_state;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div_lat;
    logic [NBITS-1:0] r_pdm_din;
    logic             r_tick;
    logic             r_underrun;

    logic [LW-1:0]    w_level;
    logic             w_full;
    logic             w_empty;
    logic [NBITS-1:0] w_head;
    logic             w_active;
    logic             w_tick;
    logic             w_disable;
    logic             w_push;
    logic             w_pop;
    logic             w_urun_evt;
    logic [NBITS:0]   w_diff;
    logic [NBITS:0]   w_mag;
    logic [NBITS-1:0] w_ramp_nxt;

    // Any handshake that completes is stored, so s_ready depends only on registered occupancy.
    assign s_ready    = enable && !rst && !w_full;
    assign w_push     = s_valid && s_ready;
    assign w_active   = (r_state == ST_RUN) || (r_state == ST_RAMP);
    assign w_tick     = w_active && (r_cnt == r_div_lat);
    // Dropping enable while filling or playing abandons the buffered audio and fades out.
    assign w_disable  = !enable && ((r_state == ST_PREFILL) || (r_state == ST_RUN));
    assign w_pop      = (r_state == ST_RUN) && enable && w_tick && !w_empty;
    assign w_urun_evt = (r_state == ST_RUN) && enable && w_tick && w_empty;

    pdm_sample_fifo #(
        .NBITS (NBITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_disable),
        .i_wdata (s_data),
        .o_rdata (w_head),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Next ramp value: one step toward midscale, snapping to it when within a step.
    always_comb begin
        w_diff     = {1'b0, r_pdm_din} - {1'b0, MID};
        w_mag      = w_diff[NBITS] ? (~w_diff + 1'b1) : w_diff;
        w_ramp_nxt = MID;
        if (w_mag > {1'b0, RAMP_STEP})
            w_ramp_nxt = w_diff[NBITS] ? (r_pdm_din + RAMP_STEP) : (r_pdm_din - RAMP_STEP);
    end

    // Period counter: free-runs in RUN/RAMP, otherwise parked at 0 tracking the live divider.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_div_lat <= '0;
        end else if (w_active) begin
            if (w_tick) begin
                r_cnt     <= '0;
                r_div_lat <= div;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt     <= '0;
            r_div_lat <= div;
        end
    end

    // Sequencer FSM with registered sample output, tick strobe and sticky underrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pdm_din  <= MID;
            r_tick     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (w_urun_evt)        r_underrun <= 1'b1;
            else if (underrun_clr) r_underrun <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_pdm_din <= MID;
                    if (enable) r_state <= ST_PREFILL;
                end
                ST_PREFILL: begin
                    if (!enable)               r_state <= ST_RAMP;
                    else if (w_level >= L_HALF) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!enable) begin
                        r_state <= ST_RAMP;
                    end else if (w_tick) begin
                        if (w_empty) begin
                            r_state <= ST_RAMP;
                        end else begin
                            r_pdm_din <= w_head;
                            r_tick    <= 1'b1;
                        end
                    end
                end
                ST_RAMP: begin
                    if (w_tick) begin
                        r_pdm_din <= w_ramp_nxt;
                        r_tick    <= 1'b1;
                    end
                    if (r_pdm_din == MID) r_state <= enable ? ST_PREFILL : ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign pdm_din     = r_pdm_din;
    assign sample_tick = r_tick;
    assign underrun    = r_underrun;
    assign level       = w_level;

endmodule

// File: tb/tb_pdm_sample_sequencer.sv
// Self-checking bench for pdm_sample_sequencer: queue-based reference model plus directed literals.
module tb_pdm_sample_sequencer;

    localparam int          DEP  = 4;
    localparam logic [15:0] MID  = 16'h8000;
    localparam logic [15:0] STEP = 16'h1000;
    localparam int P_IDLE = 0, P_FILL = 1, P_PLAY = 2, P_FADE = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] div = 16'd3;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        underrun_clr = 1'b0;
    logic        s_ready;
    logic [15:0] pdm_din;
    logic        sample_tick;
    logic        underrun;
    logic [2:0]  level;

    pdm_sample_sequencer #(
        .NBITS(16), .DEPTH(DEP), .DIV_W(16), .RAMP_STEP(16'h1000)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .div(div),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .pdm_din(pdm_din), .sample_tick(sample_tick),
        .underrun(underrun), .underrun_clr(underrun_clr), .level(level)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // reference model state
    logic [15:0] mq[$];
    logic [15:0] m_din = MID;
    bit          m_tick = 0;
    bit          m_urun = 0;
    int          m_mode = P_IDLE;
    int          m_cnt = 0;
    int          m_per = 0;
    bit          cmp_on = 0;
    logic [15:0] tlog[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] toward(input logic [15:0] x);
        if (x > MID) return ((x - MID) <= STEP) ? MID : x - STEP;
        return ((MID - x) <= STEP) ? MID : x + STEP;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit fire, drop, acc, set;
        int nm;
        if (rst) begin
            mq.delete(); m_din = MID; m_tick = 0; m_urun = 0;
            m_mode = P_IDLE; m_cnt = 0; m_per = 0;
            return;
        end
        fire = (m_mode == P_PLAY || m_mode == P_FADE) && (m_cnt == m_per);
        drop = !enable && (m_mode == P_FILL || m_mode == P_PLAY);
        acc  = s_valid && enable && (mq.size() < DEP);
        set  = 0;
        nm   = m_mode;
        m_tick = 0;
        case (m_mode)
            P_IDLE: begin m_din = MID; if (enable) nm = P_FILL; end
            P_FILL: begin
                if (drop) nm = P_FADE;
                else if (mq.size() >= DEP / 2) nm = P_PLAY;
            end
            P_PLAY: begin
                if (drop) nm = P_FADE;
                else if (fire) begin
                    if (mq.size() == 0) begin set = 1; nm = P_FADE; end
                    else begin m_din = mq.pop_front(); m_tick = 1; end
                end
            end
            default: begin
                if (m_din == MID) nm = enable ? P_FILL : P_IDLE;
                if (fire) begin m_din = toward(m_din); m_tick = 1; end
            end
        endcase
        if (drop) mq.delete();
        else if (acc) mq.push_back(s_data);
        if (m_mode == P_PLAY || m_mode == P_FADE) begin
            if (fire) begin m_cnt = 0; m_per = div; end
            else m_cnt++;
        end else begin
            m_cnt = 0; m_per = div;
        end
        m_urun = set ? 1'b1 : (underrun_clr ? 1'b0 : m_urun);
        m_mode = nm;
    endtask

    // One clock: drive on the falling edge, compare every output, then step the model.
    task automatic cyc(input bit en, input logic [15:0] dv, input logic [15:0] sd,
                       input bit sv, input bit clr, input bit rs);
        @(negedge clk);
        enable = en; div = dv; s_data = sd; s_valid = sv; underrun_clr = clr; rst = rs;
        #1;
        if (cmp_on) begin
            chk("pdm_din", pdm_din, m_din);
            chk("sample_tick", sample_tick, m_tick);
            chk("underrun", underrun, m_urun);
            chk("level", level, mq.size());
            chk("s_ready", s_ready, (!rs && en && mq.size() < DEP));
        end
        if (sample_tick) tlog.push_back(pdm_din);
        model_step();
        cmp_on = 1;
    endtask

    initial begin
        logic [15:0] exp3[11];
        logic [15:0] exp5[7];
        int full_seen, seen, found;
        bit en_r;
        exp3 = '{16'h0100, 16'h0200, 16'h0300, 16'h1300, 16'h2300, 16'h3300,
                 16'h4300, 16'h5300, 16'h6300, 16'h7300, 16'h8000};
        exp5 = '{16'hE000, 16'hD000, 16'hC000, 16'hB000, 16'hA000, 16'h9000, 16'h8000};

        // reset
        repeat (2) cyc(0, 3, 0, 0, 0, 1);
        chk("rst_din", pdm_din, 16'h8000);
        chk("rst_sready", s_ready, 0);

        // 1: enabled but starved -> no ticks, midscale held
        tlog.delete();
        repeat (6) cyc(1, 3, 0, 0, 0, 0);
        chk("s1_din", pdm_din, 16'h8000);
        chk("s1_ticks", tlog.size(), 0);
        chk("s1_level", level, 0);

        // 2/3: three samples, play out, underrun, ramp back to midscale
        cyc(1, 3, 16'h0100, 1, 0, 0);
        cyc(1, 3, 16'h0200, 1, 0, 0);
        cyc(1, 3, 16'h0300, 1, 0, 0);
        repeat (60) cyc(1, 3, 0, 0, 0, 0);
        chk("s3_nticks", tlog.size(), 11);
        for (int i = 0; i < 11; i++)
            chk($sformatf("s3_tick%0d", i), (i < tlog.size()) ? int'(tlog[i]) : -1, exp3[i]);
        chk("s3_underrun", underrun, 1);
        chk("s3_din", pdm_din, 16'h8000);

        // 4: keep the FIFO saturated; full blocks s_ready until a pop frees a slot
        cyc(1, 3, 0, 0, 1, 0);
        full_seen = 0;
        repeat (24) begin
            cyc(1, 3, 16'($urandom), 1, 0, 0);
            if (level == 3'd4 && s_ready == 1'b0) full_seen++;
        end
        chk("s4_full_blocks", full_seen > 0, 1);

        // 5: disable while playing F000 -> flush and ramp down to IDLE
        cyc(0, 3, 0, 0, 0, 1);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            cyc(1, 3, 16'hF000, 1, 0, 0);
            if (sample_tick && pdm_din == 16'hF000) found = 1;
        end
        chk("s5_reach_F000", found, 1);
        tlog.delete();
        repeat (45) cyc(0, 3, 0, 0, 0, 0);
        chk("s5_nticks", tlog.size(), 7);
        for (int i = 0; i < 7; i++)
            chk($sformatf("s5_tick%0d", i), (i < tlog.size()) ? int'(tlog[i]) : -1, exp5[i]);
        chk("s5_level", level, 0);
        chk("s5_sready", s_ready, 0);

        // 6a: reset in the middle of a ramp
        cyc(0, 3, 0, 0, 0, 1);
        cyc(1, 3, 16'hF000, 1, 0, 0);
        cyc(1, 3, 16'hF000, 1, 0, 0);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cyc(1, 3, 0, 0, 0, 0);
            if (underrun) seen = 1;
        end
        chk("s6_underrun_set", seen, 1);
        repeat (5) cyc(1, 3, 0, 0, 0, 0);
        cyc(1, 3, 0, 0, 0, 1);
        cyc(1, 3, 0, 0, 0, 0);
        chk("s6_rst_din", pdm_din, 16'h8000);
        chk("s6_rst_urun", underrun, 0);
        chk("s6_rst_level", level, 0);

        // 6b: clear held through the underrun event -> set still wins
        cyc(0, 3, 0, 0, 0, 1);
        cyc(1, 3, 16'h1234, 1, 1, 0);
        cyc(1, 3, 16'h4321, 1, 1, 0);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cyc(1, 3, 0, 0, 1, 0);
            if (underrun) seen = 1;
        end
        chk("s6_set_wins", seen, 1);

        // randomized traffic against the model
        en_r = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(39) == 0) en_r = !en_r;
            cyc(en_r, 16'($urandom_range(3)), 16'($urandom), $urandom_range(1) == 1,
                $urandom_range(31) == 0, $urandom_range(499) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pdm_sample_sequencer.md
# pdm_sample_sequencer

Sample-rate scheduler that feeds the `din` input of the pulse-density modulator. It accepts audio samples from an upstream producer over a valid/ready stream and buffers them in a small FIFO. It releases one sample per programmable sample period and, on underrun or disable, ramps the output to midscale (silence) instead of stepping. It sits between the audio source and the PDM instance in the same clock domain.

## Interface
- `NBITS`, 16: sample width; matches the PDM `NBITS`; samples are unsigned offset-binary.
- `DEPTH`, 4: FIFO depth; power of two, ≥ 2.
- `DIV_W`, 16: width of the period divider.
- `RAMP_STEP`, 16'h1000: per-tick step magnitude while ramping to midscale.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: run request.
- `div` in `DIV_W`: sample period minus 1, in `clk` cycles.
- `s_data` in `NBITS`: input sample.
- `s_valid` in 1: input sample is valid.
- `s_ready` out 1: sample accepted when `s_valid` and `s_ready` are both high on a rising edge.
- `pdm_din` out `NBITS`: registered; drives PDM `din`.
- `sample_tick` out 1: one-cycle pulse, high in the cycle `pdm_din` takes a new value.
- `underrun` out 1: sticky flag.
- `underrun_clr` in 1: clears `underrun`.
- `level` out `$clog2(DEPTH)+1`: FIFO occupancy.

## Operation
- `MID` = 2^(`NBITS`-1).
- States:
  - IDLE: hold `pdm_din`=`MID`. `enable`=1 → PREFILL.
  - PREFILL: accept samples. The tick counter is held at 0. When `level` ≥ `DEPTH`/2 → RUN.
  - RUN: on each tick, pop the FIFO head into `pdm_din`. If the FIFO is empty at a tick: no pop, `pdm_din` holds, `underrun`←1, next state RAMP.
  - RAMP: on each tick, move `pdm_din` toward `MID` by `RAMP_STEP`, clamped to `MID` with no overshoot. When `pdm_din`=`MID`: `enable`=1 → PREFILL (FIFO contents retained); `enable`=0 → IDLE.
- `enable`=0 in PREFILL or RUN → RAMP next cycle; the FIFO is flushed in that cycle.
- `s_ready` = `enable` & !`rst` & (`level` < `DEPTH`).
  - Push is accepted in PREFILL, RUN and RAMP (with `enable`=1).
  - A push and a pop in the same cycle are both honoured; `level` is unchanged.
  - No bypass: a sample pushed in the same cycle as a tick into an empty FIFO does not satisfy that tick, so underrun is taken.
- Ramp arithmetic: use an `NBITS`+1-bit difference. If |`pdm_din`−`MID`| ≤ `RAMP_STEP`, load `MID`; otherwise add or subtract `RAMP_STEP`.
- `underrun_clr` and an underrun event in the same cycle: set wins.
- `rst` mid-operation: next cycle is IDLE with the FIFO empty, regardless of state.

## Timing
- Reset values: `pdm_din`=`MID`, `sample_tick`=0, `underrun`=0, `level`=0, `s_ready`=0 while `rst` is high. The tick counter and the state (IDLE) also reset.
- Tick generation:
  - The counter runs only in RUN and RAMP.
  - A tick occurs when counter = `div_latched`; the counter then wraps to 0.
  - `div_latched` is loaded from `div` on entry to RUN and at each wrap.
  - `div`=0 gives a tick every cycle.
- The first tick comes `div`+1 cycles after entry to RUN.
- The pop, the `pdm_din` update and `sample_tick` all take effect on the same edge. Output latency from tick to `pdm_din` is 1 cycle, registered.
- `level` updates on the edge after a push or pop.
- `s_ready` is combinational from registered state only; it has no path from `s_valid`.

## Structure
- Shared package `pdm_pkg`: state encoding (IDLE/PREFILL/RUN/RAMP) and a `MID` helper for a given `NBITS`. The PDM and this block share `NBITS`.
- Sub-module `pdm_sample_fifo`: synchronous FIFO with `DEPTH` entries and `NBITS` width. It provides push, pop, flush, `level`, full and empty; pointers are `$clog2(DEPTH)` bits with wrap-around.
- Top level: FSM, tick counter, ramp datapath and status.

## Test plan
Common settings: `NBITS`=16, `DEPTH`=4, `div`=3, `RAMP_STEP`=16'h1000.
1. Reset, then `enable`=1 with no pushes → stays in PREFILL, `pdm_din`=16'h8000, no `sample_tick`.
2. Push 16'h0100, 16'h0200, 16'h0300 → RUN after the 2nd push. Ticks occur every 4 cycles with `pdm_din`=0100, 0200, 0300 in order. `level` is observed going 2→3→2→1→0 as pushes and pops interleave.
3. Continue from scenario 2 with no further pushes → at the 4th tick `underrun`=1 and `pdm_din` holds 0300. Subsequent ticks step it through 1300 … 7300, then to 8000 (clamped). The state then returns to PREFILL.
4. FIFO full at 4 entries; on a tick cycle drive `s_valid`=1 → `s_ready`=0 at that edge and no push. `level` goes 4→3. The next cycle has `s_ready`=1.
5. In RUN with `pdm_din`=16'hF000, drop `enable` → FIFO flushed and `level`=0. Ramp ticks give E000, D000 … 9000, 8000, then IDLE. `s_ready`=0 throughout.
6. Assert `rst` mid-RAMP → next cycle IDLE, `pdm_din`=8000, `underrun`=0. Separately, `underrun_clr` coincident with an underrun event leaves `underrun`=1.
